// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and the
// related BCD adder blocks: FSM state encoding and digit-adjust constants.
package bin_to_bcd_seq_pkg;

  // Converter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Double-dabble digit correction: any nibble at or above the threshold
  // gets the adjust value added before the next shift.
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // True when a BCD nibble needs the add-3 correction
  function automatic logic needs_adj(input logic [3:0] nib);
    return (nib >= ADJ_THRESH);
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Per-nibble add-3 correction used by the double-dabble shift datapath.
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Add 3 to nibbles of 5 or more, pass smaller nibbles through unchanged
  always_comb begin
    dout = din;
    if (needs_adj(din)) begin
      dout = din + ADJ_ADD;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle)
// with valid/ready handshakes on both sides.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  // Counter must hold WIDTH without wrapping
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int CAT_W = 4 * DIGITS + WIDTH;

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [WIDTH-1:0]      shreg_r;
  logic [4*DIGITS-1:0]   acc_r;

  logic [4*DIGITS-1:0]   adj_s;
  logic [CAT_W-1:0]      cat_s;
  logic [4*DIGITS-1:0]   acc_next_s;
  logic [WIDTH-1:0]      shreg_next_s;

  // One add-3 corrector per accumulator digit
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc_r[4*g +: 4]),
      .dout (adj_s[4*g +: 4])
    );
  end

  // One double-dabble step: corrected accumulator and operand shift left together
  assign cat_s        = {adj_s, shreg_r} << 1;
  assign acc_next_s   = cat_s[CAT_W-1:WIDTH];
  assign shreg_next_s = cat_s[WIDTH-1:0];

  // Control FSM, iteration counter, shift datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      shreg_r   <= '0;
      acc_r     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd       <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            shreg_r  <= bin;
            acc_r    <= '0;
            cnt_r    <= '0;
            state_r  <= ST_SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          acc_r   <= acc_next_s;
          shreg_r <= shreg_next_s;
          cnt_r   <= cnt_r + CNT_ONE;
          // Last iteration: publish the result on the same edge it completes
          if (cnt_r == LAST_CNT) begin
            state_r   <= ST_DONE;
            out_valid <= 1'b1;
            bcd       <= acc_next_s;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
            bcd       <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= '0;
          shreg_r   <= '0;
          acc_r     <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          bcd       <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed vector table, hold and
// reset sequences, and a randomized back-to-back sweep against a decimal model.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd;
  logic        busy;

  int n_cmp;
  int n_err;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp;
    int          hold;
  } vec_t;

  // Decimal reference: digits by division, packed MSD-first
  function automatic logic [11:0] ref_bcd(input int v);
    int d0, d1, d2;
    d0 = v % 10;
    d1 = (v / 10) % 10;
    d2 = (v / 100) % 10;
    return 12'((d2 << 8) | (d1 << 4) | d0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction: present operand, scramble inputs during the
  // conversion, check latency and result, hold in DONE, then handshake.
  // Called at posedge+1 with the DUT in IDLE.
  task automatic run_one(input logic [7:0] v, input logic [11:0] exp, input int hold,
                         input bit rand_ready);
    int lat;
    chk("in_ready before accept", in_ready, 1);
    in_valid  = 1'b1;
    bin       = v;
    out_ready = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      bin       = 8'($urandom);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
      chk("bcd zero in shift", bcd, 0);
      chk("in_ready low in shift", in_ready, 0);
      chk("busy in shift", busy, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("latency", lat, 8);
    chk("result", bcd, exp);
    chk("nibble range", (bcd[3:0] > 4'd9) || (bcd[7:4] > 4'd9) || (bcd[11:8] > 4'd9), 0);
    chk("in_ready low in done", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("out_valid held", out_valid, 1);
      chk("bcd held", bcd, exp);
      chk("in_ready held low", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
    chk("out_valid after handshake", out_valid, 0);
    chk("in_ready after handshake", in_ready, 1);
    chk("bcd cleared after handshake", bcd, 0);
    chk("busy after handshake", busy, 0);
  endtask

  vec_t vecs[8];
  int   stale;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bin       = 8'd0;
    out_ready = 1'b0;

    vecs[0] = '{bin: 8'd255, exp: 12'h255, hold: 0};
    vecs[1] = '{bin: 8'd0,   exp: 12'h000, hold: 0};
    vecs[2] = '{bin: 8'd9,   exp: 12'h009, hold: 1};
    vecs[3] = '{bin: 8'd10,  exp: 12'h010, hold: 0};
    vecs[4] = '{bin: 8'd99,  exp: 12'h099, hold: 2};
    vecs[5] = '{bin: 8'd128, exp: 12'h128, hold: 5};
    vecs[6] = '{bin: 8'd200, exp: 12'h200, hold: 0};
    vecs[7] = '{bin: 8'd101, exp: 12'h101, hold: 0};

    // Reset state
    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset bcd", bcd, 0);
    chk("reset busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle in_ready", in_ready, 1);
    chk("idle busy", busy, 0);

    // out_ready outside DONE does nothing
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle out_valid with out_ready", out_valid, 0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i].bin, vecs[i].exp, vecs[i].hold, 1'b0);
    end

    // Reset in the 4th SHIFT cycle discards the conversion
    in_valid = 1'b1;
    bin      = 8'd77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("busy before reset", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset bcd", bcd, 0);
    chk("async reset busy", busy, 0);
    chk("async reset in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("no stale out_valid", stale, 0);
    run_one(8'd37, 12'h037, 0, 1'b0);

    // Exhaustive sweep, back-to-back, random out_ready and hold
    for (int v = 0; v < 256; v++) begin
      run_one(8'(v), ref_bcd(v), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the binary input width in bits.
REQ-002 The block SHALL have parameter DIGITS, default 3, giving the number of BCD output digits; DIGITS SHALL satisfy 10^DIGITS > 2^WIDTH - 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the binary operand on bin is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand.
REQ-007 The block SHALL have port bin, input, WIDTH bits: unsigned binary operand.
REQ-008 The block SHALL have port out_valid, output, 1 bit: bcd holds a completed result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port bcd, output, 4*DIGITS bits: packed BCD result, most significant digit in the top nibble.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on a rising edge with in_valid=1, latch bin into a shift register, clear the BCD accumulator, clear the iteration counter and go to SHIFT.
REQ-014 SHIFT: in_ready=0, out_valid=0; each edge performs one double-dabble iteration: every accumulator nibble >= 5 gets +3, then {accumulator, shift register} shifts left one bit.
REQ-015 After exactly WIDTH iterations the FSM SHALL go to DONE; the counter SHALL be wide enough for WIDTH with no wrap before termination.
REQ-016 Latency: an operand accepted at edge k SHALL produce out_valid=1 immediately after edge k+WIDTH (8 cycles for the defaults).
REQ-017 DONE: out_valid=1, in_ready=0, bcd stable; on an edge with out_ready=1 go to IDLE, otherwise hold bcd and out_valid unchanged indefinitely.
REQ-018 in_ready SHALL be 0 in the DONE cycle even if out_ready=1; a new operand is accepted no earlier than the cycle after the output handshake.
REQ-019 in_valid and bin SHALL be ignored outside IDLE; changes to bin after acceptance SHALL NOT affect the result.
REQ-020 bcd SHALL equal the decimal value of the accepted operand, each nibble in 0-9; for the defaults, 255 gives 0x255 and 0 gives 0x000.
REQ-021 bcd SHALL read zero in IDLE and SHIFT, and SHALL show the result only while out_valid=1.
REQ-022 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, counter 0, shift register and accumulator 0, out_valid=0, bcd=0, busy=0, and in_ready=1 once rst_n is released.
REQ-024 Reset asserted during SHIFT or DONE SHALL discard the in-flight conversion; no out_valid pulse for it SHALL appear after release.
REQ-025 The first operand SHALL be accepted no earlier than the first rising edge at which rst_n=1.

Structure
REQ-026 The FSM state encodings and a digit-adjust constant (value 3, threshold 5) SHALL live in the shared package so the BCD adder family can reuse them.
REQ-027 The per-nibble add-3 correction SHALL be a combinational sub-module bcd_digit_adj (4-bit in, 4-bit out), instantiated DIGITS times.
REQ-028 No other sub-module SHALL be used; the FSM, counter and shift datapath SHALL reside in bin_to_bcd_seq.

Verification
REQ-029 Apply bin=8'd255 with in_valid=1 and out_ready=1 -> out_valid rises 8 cycles after acceptance with bcd=12'h255, then the block returns to IDLE.
REQ-030 Apply bin=0, then 9, 10 and 99 -> bcd=12'h000, 12'h009, 12'h010 and 12'h099 respectively.
REQ-031 Apply bin=8'd128 with out_ready=0 for 5 cycles after out_valid -> bcd=12'h128 held stable, in_ready=0 throughout, and exactly one handshake when out_ready rises.
REQ-032 Accept 8'd200, then toggle bin and in_valid during SHIFT -> result is 12'h200 and the extra inputs are ignored.
REQ-033 Assert rst_n=0 in the 4th SHIFT cycle -> outputs are zero immediately, no stale out_valid follows, and a next conversion of 8'd37 gives 12'h037.
REQ-034 Run an exhaustive sweep 0-255 back-to-back with random out_ready -> every result matches a reference decimal model and no nibble exceeds 9.
